// File: rtl/down_count_timer.sv
// Programmable countdown timer: loadable WIDTH-bit down counter with a
// RUN/PAUSED/DONE control FSM, terminal-count strobe and saturating reload tally.
module down_count_timer #(
    parameter int WIDTH = 6,
    parameter int RCW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse,
    output logic [RCW-1:0]   reload_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RCW-1:0]   RC_ZERO  = {RCW{1'b0}};
    localparam logic [RCW-1:0]   RC_ONE   = {{(RCW-1){1'b0}}, 1'b1};
    localparam logic [RCW-1:0]   RC_MAX   = {RCW{1'b1}};

    function automatic logic [RCW-1:0] sat_inc(input logic [RCW-1:0] v);
        return (v == RC_MAX) ? v : v + RC_ONE;
    endfunction

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [RCW-1:0]   rcnt_q,   rcnt_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state and datapath: abort > start > terminal count > pause > decrement.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        rcnt_d   = rcnt_q;
        tc_d     = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_RUN;
                        count_d  = load_val;
                        reload_d = load_val;
                        rcnt_d   = RC_ZERO;
                        tc_d     = (load_val == CNT_ZERO);
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    if (count_q == CNT_ZERO) begin
                        if (auto_reload) begin
                            count_d = reload_q;
                            rcnt_d  = sat_inc(rcnt_q);
                            tc_d    = (reload_q == CNT_ZERO);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (pause && (count_q != CNT_ONE)) begin
                        // At count 1 the final decrement beats a simultaneous pause.
                        state_d = ST_PAUSED;
                    end else begin
                        count_d = count_q - CNT_ONE;
                        tc_d    = (count_q == CNT_ONE);
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            rcnt_q   <= RC_ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            rcnt_q   <= rcnt_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tc_pulse   = tc_q;
    assign reload_cnt = rcnt_q;

endmodule
